bram_frame_reader: RTL
======================

Name: bram_frame_reader

Overview:
Read-side controller for the ping-pong frame BRAM. On a start request it walks one bank of the simple dual-port BRAM read port (address, port enable, 1-cycle registered read data). It presents the pixels as a valid/ready stream with last-pixel marking and a completion pulse. It sits entirely in the read clock domain, between the BRAM read port and the downstream pixel consumer (e.g. display/scan-out).

Parameters:
BRAM_WIDTH, 12, pixel/data width in bits
FRAME_PIXELS, 76800, pixels per bank (one frame)
BRAM_DEPTH, 153600, total BRAM words; must equal 2*FRAME_PIXELS (bank 0 at 0, bank 1 at FRAME_PIXELS)

Ports:
i_clk  in  1  read-domain clock; also clocks the BRAM read port
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request to read a frame; honoured only in IDLE
i_bank  in  1  bank to read, sampled with i_start
o_busy  out  1  high from accepted start until frame fully delivered
o_done  out  1  one-cycle pulse after the last pixel handshake
o_rportEn  out  1  BRAM read port enable (one read issued per high cycle)
o_raddr  out  $clog2(BRAM_DEPTH)  BRAM read address
i_rdata  in  BRAM_WIDTH  BRAM read data, valid the cycle after o_rportEn
o_tdata  out  BRAM_WIDTH  output pixel
o_tvalid  out  1  o_tdata valid
i_tready  in  1  consumer accepts pixel when o_tvalid && i_tready
o_tlast  out  1  high with the final pixel of the frame

Behaviour:
- Reset (async assert, sync-release assumed upstream): state IDLE. o_busy, o_done, o_rportEn, o_tvalid, o_tlast = 0. o_raddr = 0, o_tdata = 0. Read counter and skid buffer empty.
- States: IDLE -> ISSUE on i_start. ISSUE -> DRAIN once FRAME_PIXELS reads have been issued. DRAIN -> IDLE when the last pixel handshakes (o_tvalid && i_tready && o_tlast). o_done pulses the cycle after that handshake; o_busy falls in the same cycle.
- i_start outside IDLE ignored. i_start in the cycle o_done pulses is accepted (back-to-back frames).
- Base address = i_bank ? FRAME_PIXELS : 0, latched at start. o_raddr = base + index, index 0..FRAME_PIXELS-1, no wrap beyond the bank.
- Read issue rule: o_rportEn high only when (reads in flight + skid entries) < 2. In flight is 0 or 1, because the BRAM latency is 1 cycle. This guarantees no data is lost when i_tready is low.
- Capture: the cycle after o_rportEn, i_rdata is pushed into a 2-entry skid FIFO together with its last flag (index == FRAME_PIXELS-1 at issue). The FIFO head drives o_tdata/o_tlast; o_tvalid = FIFO non-empty.
- Throughput: with i_tready held high, one pixel per cycle. First o_tvalid is 2 cycles after the i_start cycle (cycle 1 issue, cycle 2 data registered). A frame completes in FRAME_PIXELS+2 cycles plus stall cycles.
- Backpressure: o_tdata/o_tlast stable while o_tvalid && !i_tready. Issue stops when the FIFO would overflow and resumes the cycle after space frees.
- Simultaneous push and pop on the FIFO is allowed at any occupancy, including full (count unchanged).
- o_raddr holds its last value when o_rportEn is low.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded and no o_done is produced.

Decomposition:
- Package bram_reader_pkg: state enum {IDLE, ISSUE, DRAIN}; localparam ADDR_W = $clog2(BRAM_DEPTH); localparam SKID_DEPTH = 2.
- Sub-module rd_skid_fifo: 2-entry FIFO of {last, data}, same clock/reset. Ports push/pop/data_in/data_out/count/empty. The top holds the FSM, the address counter and the credit logic.

Test Plan:
- FRAME_PIXELS=8, BRAM_DEPTH=16, mem[i]=i+0x100. Start bank 0, tready=1 -> o_tdata 0x100..0x107 on 8 consecutive cycles, first valid 2 cycles after start, o_tlast on 0x107, o_done 1 cycle later.
- Start bank 1 -> o_raddr runs 8..15, o_tdata 0x108..0x10F, o_tlast with 0x10F.
- tready toggling 1,0,0,1,... -> every pixel delivered exactly once and in order. o_tdata stable during stalls. At no time are reads in flight plus stored entries more than 2.
- i_start pulsed while busy -> ignored: a single frame of 8 pixels and one o_done. A start in the o_done cycle -> second frame begins, 16 pixels total, 2 done pulses.
- i_rstn low after pixel 3 -> all outputs 0 asynchronously, no o_done. A new start afterwards -> a full correct 8-pixel frame.
- tready=0 for 20 cycles after start -> exactly 2 reads issued, o_tvalid high with 0x100 stable. On release, the remaining 6 reads issue and the frame completes correctly.

Source files
------------

// File: rtl/bram_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_reader_pkg                                                      |
// | Shared types and constants for the ping-pong frame BRAM read side.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BRAM_DEPTH_DEFAULT = 153600;
    localparam int ADDR_W             = $clog2(BRAM_DEPTH_DEFAULT);
    localparam int SKID_DEPTH         = 2;

endpackage

`default_nettype wire

// File: rtl/rd_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rd_skid_fifo                                                         |
// | Small skid FIFO catching BRAM read data while the consumer stalls.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rd_skid_fifo
    import bram_reader_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  logic [WIDTH-1:0]                  data_in,
    output logic [WIDTH-1:0]                  data_out,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   count,
    output logic                              empty
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is fine as long as the head leaves in the same cycle.
    assign do_push  = push && ((count < CNT_W'(SKID_DEPTH)) || do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_frame_reader                                                    |
// | Walks one bank of the frame BRAM and streams it out as valid/ready.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bram_frame_reader
    import bram_reader_pkg::*;
#(
    parameter int BRAM_WIDTH   = 12,
    parameter int FRAME_PIXELS = 76800,
    parameter int BRAM_DEPTH   = 153600
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_start,
    input  logic                          i_bank,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_rportEn,
    output logic [$clog2(BRAM_DEPTH)-1:0] o_raddr,
    input  logic [BRAM_WIDTH-1:0]         i_rdata,
    output logic [BRAM_WIDTH-1:0]         o_tdata,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic                          o_tlast
);

    localparam int RADDR_W = $clog2(BRAM_DEPTH);
    localparam int IDX_W   = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int CNT_W   = $clog2(SKID_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     cur_idx;
    logic [RADDR_W-1:0]   base;
    logic [RADDR_W-1:0]   bank_base;
    logic [RADDR_W-1:0]   cur_base;
    logic [RADDR_W-1:0]   hold_addr;
    logic                 inflight;
    logic                 inflight_last;
    logic                 done;
    logic                 issue;
    logic                 last_issue;
    logic                 pop;
    logic                 last_hs;
    logic                 credit_ok;
    logic [2:0]           occupancy;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [BRAM_WIDTH:0]  fifo_head;

    assign bank_base = i_bank ? RADDR_W'(FRAME_PIXELS) : '0;
    assign cur_base  = (state == IDLE) ? bank_base : base;
    assign cur_idx   = (state == IDLE) ? '0 : idx;

    assign pop     = o_tvalid && i_tready;
    assign last_hs = pop && o_tlast;

    // Count the slot freed by this cycle's pop so a ready consumer sees one pixel per cycle.
    assign occupancy  = 3'(inflight) + 3'(fifo_count) - 3'(pop);
    assign credit_ok  = (occupancy < 3'(SKID_DEPTH));
    assign issue      = credit_ok && (((state == IDLE) && i_start) || (state == ISSUE));
    assign last_issue = issue && (cur_idx == LAST_IDX);

    assign o_rportEn = issue;
    assign o_raddr   = issue ? (cur_base + RADDR_W'(cur_idx)) : hold_addr;
    assign o_busy    = (state != IDLE);
    assign o_done    = done;
    assign o_tvalid  = !fifo_empty;
    assign o_tlast   = fifo_head[BRAM_WIDTH];
    assign o_tdata   = fifo_head[BRAM_WIDTH-1:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start)    state_next = last_issue ? DRAIN : ISSUE;
            ISSUE:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_hs)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            idx           <= '0;
            base          <= '0;
            hold_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            if ((state == IDLE) && i_start) begin
                base <= bank_base;
            end
            if (issue) begin
                idx       <= cur_idx + IDX_W'(1);
                hold_addr <= o_raddr;
            end else if (state == IDLE) begin
                idx <= '0;
            end
            inflight      <= issue;
            inflight_last <= last_issue;
            done          <= last_hs;
        end
    end

    rd_skid_fifo #(
        .WIDTH (BRAM_WIDTH + 1)
    ) u_skid (
        .clk      (i_clk),
        .rst_n    (i_rstn),
        .push     (inflight),
        .pop      (pop),
        .data_in  ({inflight_last, i_rdata}),
        .data_out (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule

`default_nettype wire
